sw_event_scheduler: RTL
=======================

Name: sw_event_scheduler

Overview:
- Shared debounce and event controller for the board's user push-switches.
- Owns the debounce sample-enable timing and sequences debounce evaluation across all switches.
- Reports press, release and long-press events through one valid/ready event queue for the control logic.
- Also publishes the debounced level of every switch.

Parameters:
- pSwNum, 4: number of switch inputs, 1..16.
- pTickDiv, 50000: iSysClk cycles per debounce sample tick. Must be greater than pSwNum+3.
- pStableLen, 3: consecutive equal samples required to change a debounced level, 2..8.
- pLongCnt, 100: ticks a switch must stay pressed, after its press event, before the long-press event.
- pFifoDepth, 4: event queue depth, power of two.

Ports:
- iSysClk  in  1  system clock.
- iSysRst  in  1  asynchronous reset, active-low.
- iUserSw  in  pSwNum  raw switch inputs, asynchronous, active-high.
- oSwLevel  out  pSwNum  debounced levels.
- oEvtValid  out  1  event queue head valid.
- oEvtCode  out  2  event type: 01 press, 10 release, 11 long-press.
- oEvtId  out  4  switch index of the event.
- iEvtReady  in  1  consumer pops the head when oEvtValid is also high.
- oOvf  out  1  sticky overflow flag.
- iOvfClr  in  1  clears oOvf.
- oTick  out  1  one-cycle pulse on each sample tick.

Behaviour:
- Reset: asynchronous assert, synchronous release. Clears:
  - prescaler, shift registers, long counters;
  - oSwLevel=0, FIFO empty, oEvtValid=0, oEvtCode=0, oEvtId=0, oOvf=0, oTick=0;
  - FSM to IDLE.
- Input synchronisation: each iUserSw bit passes through a 2-FF synchroniser, not gated by the tick.
- Prescaler:
  - Counts 0..pTickDiv-1 and wraps.
  - oTick=1 for the single cycle when the count equals pTickDiv-1.
- FSM states:
  - IDLE: waits. On oTick it goes to SAMPLE.
  - SAMPLE (1 cycle): shifts every switch's synchronised bit into its pStableLen-bit history. Then goes to SCAN with index=0.
  - SCAN (pSwNum cycles): evaluates switch[index], one switch per cycle. index increments each cycle. After index=pSwNum-1 it returns to IDLE.
- Per-switch evaluation in SCAN, hysteresis:
  - History all ones and level=0: level becomes 1, push a press event, long counter=0.
  - History all zeros and level=1: level becomes 0, push a release event, long counter=0.
  - Otherwise level holds. If level=1 and the long counter is below pLongCnt, the counter increments. When the increment reaches pLongCnt, push a long-press event.
  - The long counter saturates at pLongCnt, so only one long event is sent per press.
  - At most one event is pushed per SCAN cycle.
- Event ordering:
  - Events from the same tick are queued in ascending switch index.
  - oSwLevel updates in the same cycle as the push.
- FIFO:
  - Registered output. A pushed event is visible at the head no earlier than the next cycle.
  - Pop happens when oEvtValid and iEvtReady are both high.
  - Push and pop may occur in the same cycle. This is legal when the FIFO is full: pop first, push accepted, count unchanged.
  - Push while full without a pop: the event is dropped, the level still updates, and oOvf is set to 1.
  - oEvtCode and oEvtId hold their values while oEvtValid=1 and iEvtReady=0.
- Overflow flag:
  - iOvfClr clears oOvf.
  - If iOvfClr and a new overflow occur in the same cycle, the set wins.
- Latency: a clean input edge produces its event on the pStableLen-th tick after the edge reaches the synchroniser output. The push occurs index+2 cycles after that oTick.
- Reset during SCAN or with a non-empty FIFO discards everything. No event appears after reset release until a new qualifying input.

Optional Feature:
- Macro SW_EVT_LONGPRESS_EN.
- Defined: long counters and the 11 event code are implemented as described above.
- Undefined: long counters are removed, code 11 is never generated, and only press and release events exist.

Test Plan (pSwNum=4, pTickDiv=16, pStableLen=3, pLongCnt=8, pFifoDepth=4, iEvtReady=1 unless stated):
1. Clean press: iUserSw[2] goes 0->1 and is held. On the 3rd following tick, 4 cycles after oTick, the press is pushed. oEvtValid=1 follows with oEvtCode=01, oEvtId=2, and oSwLevel=0100.
2. Chatter: iUserSw[1] toggles every 24 cycles for 20 ticks, then returns to 0. No events occur, oSwLevel[1] stays 0, oOvf=0.
3. Long press (macro defined): iUserSw[0] is held for 20 ticks after its press event, then released.
   - Expected sequence: press(01,id0); long(11,id0) exactly 8 ticks later, only once; release(10,id0).
   - With the macro undefined: press and release only.
4. Simultaneous press: iUserSw[3] and iUserSw[1] rise in the same cycle. The same tick produces two events, id1 then id3, pushed 2 cycles apart. The head order is preserved.
5. Overflow: iEvtReady=0 while 5 events are generated. Expected results:
   - 4 events are queued and the 5th is dropped.
   - oOvf=1, and oSwLevel reflects all 5 changes.
   - Pulsing iOvfClr gives oOvf=0.
   - Releasing iEvtReady drains exactly 4 events in order.
6. Reset mid-operation: iSysRst is asserted low during SCAN with 2 events queued. All outputs go to their reset values immediately. After release with inputs held at 0, no event appears for 10 ticks.

Source files
------------

// File: rtl/sw_event_scheduler.sv
// -----------------------------------------------------------------------------
// sw_event_scheduler
//   Shared debounce and event controller for the board's user push-switches.
//   A prescaler produces a sample tick. On each tick an FSM shifts every
//   synchronised switch into a history register, then scans the switches one
//   per cycle. The scan applies hysteresis and emits press / release /
//   long-press events into a small valid/ready event queue.
//
//   Optional feature macro: SW_EVT_LONGPRESS_EN
//     defined   : per-switch long counters and long-press events (code 11)
//     undefined : press (01) and release (10) events only
//
// Ports
//   iSysClk    in   system clock
//   iSysRst    in   asynchronous reset, active-low (released synchronously)
//   iUserSw    in   raw asynchronous switch inputs, active-high
//   oSwLevel   out  debounced switch levels
//   oEvtValid  out  event queue head valid
//   oEvtCode   out  event type: 01 press, 10 release, 11 long-press
//   oEvtId     out  switch index of the head event
//   iEvtReady  in   pops the head when oEvtValid is also high
//   oOvf       out  sticky overflow flag (event dropped on a full queue)
//   iOvfClr    in   clears oOvf; a simultaneous new overflow wins
//   oTick      out  one-cycle pulse on each sample tick
//
// Constraints: pSwNum 1..16, pTickDiv > pSwNum+3, pStableLen 2..8,
//              pLongCnt >= 1, pFifoDepth a power of two >= 2.
// -----------------------------------------------------------------------------
module sw_event_scheduler #(
  parameter int pSwNum     = 4,
  parameter int pTickDiv   = 50000,
  parameter int pStableLen = 3,
  parameter int pLongCnt   = 100,
  parameter int pFifoDepth = 4
) (
  input  logic              iSysClk,
  input  logic              iSysRst,
  input  logic [pSwNum-1:0] iUserSw,
  output logic [pSwNum-1:0] oSwLevel,
  output logic              oEvtValid,
  output logic [1:0]        oEvtCode,
  output logic [3:0]        oEvtId,
  input  logic              iEvtReady,
  output logic              oOvf,
  input  logic              iOvfClr,
  output logic              oTick
);

  localparam int IW = (pSwNum > 1) ? $clog2(pSwNum) : 1;
  localparam int CW = $clog2(pTickDiv);
  localparam int AW = $clog2(pFifoDepth);

  localparam logic [1:0] EVT_NONE    = 2'b00;
  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
`ifdef SW_EVT_LONGPRESS_EN
  localparam int         LW          = $clog2(pLongCnt + 1);
  localparam logic [1:0] EVT_LONG    = 2'b11;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_SCAN} state_e;

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] id;
  } evt_t;

  // Reset: asserted asynchronously, released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Input synchroniser, free-running (not gated by the tick).
  logic [pSwNum-1:0] sync1_q, sync2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iSysClk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= iUserSw;
      sync2_q <= sync1_q;
    end
  end

  // Prescaler; tick_q is registered so it is high while the count is at its top.
  logic [CW-1:0] presc_q, presc_d;
  logic          tick_q;

  assign presc_d = (presc_q == CW'(pTickDiv - 1)) ? '0 : presc_q + CW'(1);

  always_ff @(posedge iSysClk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= (presc_d == CW'(pTickDiv - 1));
    end
  end
  assign oTick = tick_q;

  // Sequencer and per-switch debounce state.
  state_e                state_q;
  logic [IW-1:0]         idx_q;
  logic [pSwNum-1:0]     level_q;
  logic [pStableLen-1:0] hist_q [pSwNum];
`ifdef SW_EVT_LONGPRESS_EN
  logic [LW-1:0]         long_q [pSwNum];
  logic                  long_inc;
`endif

  logic                  push;
  logic [1:0]            push_code;
  logic                  lvl_flip;
  logic [pStableLen-1:0] cur_hist;
  logic                  cur_lvl;

  // Evaluation of the switch currently addressed by the scan.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    cur_hist  = hist_q[idx_q];
    cur_lvl   = level_q[idx_q];
    push      = 1'b0;
    push_code = EVT_NONE;
    lvl_flip  = 1'b0;
`ifdef SW_EVT_LONGPRESS_EN
    long_inc  = 1'b0;
`endif
    if (state_q == ST_SCAN) begin
      if ((&cur_hist) && !cur_lvl) begin
        push      = 1'b1;
        push_code = EVT_PRESS;
        lvl_flip  = 1'b1;
      end else if (!(|cur_hist) && cur_lvl) begin
        push      = 1'b1;
        push_code = EVT_RELEASE;
        lvl_flip  = 1'b1;
      end
`ifdef SW_EVT_LONGPRESS_EN
      // Saturating at pLongCnt guarantees a single long event per press.
      else if (cur_lvl && (long_q[idx_q] < LW'(pLongCnt))) begin
        long_inc = 1'b1;
        if (long_q[idx_q] == LW'(pLongCnt - 1)) begin
          push      = 1'b1;
          push_code = EVT_LONG;
        end
      end
`endif
    end
  end

  always_ff @(posedge iSysClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      level_q <= '0;
      for (int i = 0; i < pSwNum; i++) begin
        hist_q[i] <= '0;
`ifdef SW_EVT_LONGPRESS_EN
        long_q[i] <= '0;
`endif
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (tick_q) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          for (int i = 0; i < pSwNum; i++)
            hist_q[i] <= {hist_q[i][pStableLen-2:0], sync2_q[i]};
          idx_q   <= '0;
          state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          // Level follows the hysteresis even when the event itself is dropped.
          if (lvl_flip) level_q[idx_q] <= ~level_q[idx_q];
`ifdef SW_EVT_LONGPRESS_EN
          if (lvl_flip)      long_q[idx_q] <= '0;
          else if (long_inc) long_q[idx_q] <= long_q[idx_q] + LW'(1);
`endif
          if (idx_q == IW'(pSwNum - 1)) state_q <= ST_IDLE;
          else                          idx_q   <= idx_q + IW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign oSwLevel = level_q;

  // Event queue. Head is read straight from storage flops, so a pushed
  // event becomes visible on the cycle after the push.
  evt_t          mem_q [pFifoDepth];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          pop, full, accept, ovf_set, ovf_q;

  assign pop     = (cnt_q != '0) && iEvtReady;
  assign full    = (cnt_q == (AW+1)'(pFifoDepth));
  assign accept  = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // NOTE: the queue storage is reset so that oEvtCode/oEvtId read zero
  // out of reset; it is only a handful of flops.
  always_ff @(posedge iSysClk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < pFifoDepth; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        mem_q[wr_q] <= '{code: push_code, id: 4'(idx_q)};
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      unique case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
      if (ovf_set)      ovf_q <= 1'b1;
      else if (iOvfClr) ovf_q <= 1'b0;
    end
  end

  assign oEvtValid = (cnt_q != '0);
  assign oEvtCode  = mem_q[rd_q].code;
  assign oEvtId    = mem_q[rd_q].id;
  assign oOvf      = ovf_q;

endmodule
